// File: rtl/blob_pkg.sv
// rtl/blob_pkg.sv - shared types and defaults for the blob frame controller
//
// Purpose: frame geometry / count-width defaults and the controller state enum
// shared by blob_frame_ctrl and frame_pos_counter.
// Ports: none (package).

package blob_pkg;

  localparam int IMG_COL_DEF = 800;
  localparam int IMG_ROW_DEF = 600;
  localparam int TIMEOUT_DEF = 100000;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } blob_ctrl_state_e;

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - column/row position counter for one frame
//
// Purpose: tracks the (row, col) position of the next accepted pixel.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : return to (0,0)
//   i_en         : one pixel accepted this cycle
//   o_last       : current position is (IMG_ROW-1, IMG_COL-1)

module frame_pos_counter
  import blob_pkg::*;
#(
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int IMG_ROW = IMG_ROW_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int COL_W = $clog2(IMG_COL > 1 ? IMG_COL : 2);
  localparam int ROW_W = $clog2(IMG_ROW > 1 ? IMG_ROW : 2);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_ROW - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (i_en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        // Wrapping the row after the last pixel leaves the counter parked at
        // (0,0), ready for the next frame even without an explicit clear.
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign o_last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/blob_frame_ctrl.sv
// rtl/blob_frame_ctrl.sv - frame sequencer in front of the blob-counting pipeline
//
// Purpose: selects CCD or SDRAM pixels, frames one IMG_COL x IMG_ROW image for
// the pipeline, then waits (bounded) for the pipeline's blob count.
// Ports:
//   i_clk, i_rst                   : clock, synchronous active-high reset
//   i_start, i_src_sdram, i_abort  : frame request, source select, abandon
//   i_ccd_valid/pix                : live binarized pixel source
//   i_sdram_valid/pix, o_sdram_request : replay pixel source and its request
//   o_blob_valid, o_blob_data_valid, o_blob_seq, o_blob_proc_ccd : pipeline side
//   i_blob_valid, i_blob_count     : pipeline result
//   o_busy, o_done, o_timeout, o_count : status and latched result

module blob_frame_ctrl
  import blob_pkg::*;
#(
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int IMG_ROW = IMG_ROW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_src_sdram,
  input  logic             i_abort,
  input  logic             i_ccd_valid,
  input  logic             i_ccd_pix,
  input  logic             i_sdram_valid,
  input  logic             i_sdram_pix,
  output logic             o_sdram_request,
  output logic             o_blob_valid,
  output logic             o_blob_data_valid,
  output logic             o_blob_seq,
  output logic             o_blob_proc_ccd,
  input  logic             i_blob_valid,
  input  logic [CNT_W-1:0] i_blob_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_count
);

  localparam int TMR_W = 17;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  blob_ctrl_state_e state_q, state_d;
  logic             src_q, src_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             sdram_req_q, sdram_req_d;
  logic             blob_valid_q, blob_valid_d;
  logic             data_valid_q, data_valid_d;
  logic             seq_q, seq_d;
  logic             proc_ccd_q, proc_ccd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic sel_valid;
  logic sel_pix;
  logic pix_en;
  logic pos_clr;
  logic pos_last;

  assign sel_valid = src_q ? i_sdram_valid : i_ccd_valid;
  assign sel_pix   = src_q ? i_sdram_pix   : i_ccd_pix;

  frame_pos_counter #(
    .IMG_COL (IMG_COL),
    .IMG_ROW (IMG_ROW)
  ) u_pos (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (pos_clr),
    .i_en   (pix_en),
    .o_last (pos_last)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    proc_ccd_d = proc_ccd_q;
    timeout_d  = timeout_q;
    count_d    = count_q;
    timer_d    = '0;
    pos_clr    = 1'b0;
    pix_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          src_d      = i_src_sdram;
          proc_ccd_d = !i_src_sdram;
          timeout_d  = 1'b0;
          pos_clr    = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (sel_valid) begin
          pix_en = 1'b1;
          if (pos_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Timer is 0 on the first DRAIN cycle; expiring when it reads TIMEOUT
        // places o_done TIMEOUT+1 cycles after DRAIN entry. A result arriving
        // on that same last cycle is checked first and so wins.
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_blob_valid) begin
          count_d = i_blob_count;
          state_d = DONE;
        end else if (timer_q == TMR_LIMIT) begin
          timeout_d = 1'b1;
          count_d   = '0;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output stage is registered from the next state so every strobe lines
    // up with the state it belongs to, with one cycle of pixel latency.
    data_valid_d = pix_en;
    seq_d        = pix_en & sel_pix;
    blob_valid_d = (state_d == STREAM);
    sdram_req_d  = (state_d == STREAM) && src_d;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      src_q        <= 1'b0;
      timer_q      <= '0;
      sdram_req_q  <= 1'b0;
      blob_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      seq_q        <= 1'b0;
      proc_ccd_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      timer_q      <= timer_d;
      sdram_req_q  <= sdram_req_d;
      blob_valid_q <= blob_valid_d;
      data_valid_q <= data_valid_d;
      seq_q        <= seq_d;
      proc_ccd_q   <= proc_ccd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign o_sdram_request   = sdram_req_q;
  assign o_blob_valid      = blob_valid_q;
  assign o_blob_data_valid = data_valid_q;
  assign o_blob_seq        = seq_q;
  assign o_blob_proc_ccd   = proc_ccd_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_timeout         = timeout_q;
  assign o_count           = count_q;

endmodule

// File: tb/tb_blob_frame_ctrl.sv
// tb/tb_blob_frame_ctrl.sv - self-checking bench for blob_frame_ctrl

module tb_blob_frame_ctrl;

  localparam int IMG_COL = 8;
  localparam int IMG_ROW = 6;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 8;
  localparam int FRAME   = IMG_COL * IMG_ROW;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_src_sdram = 1'b0;
  logic             i_abort = 1'b0;
  logic             i_ccd_valid = 1'b0;
  logic             i_ccd_pix = 1'b0;
  logic             i_sdram_valid = 1'b0;
  logic             i_sdram_pix = 1'b0;
  logic             o_sdram_request;
  logic             o_blob_valid;
  logic             o_blob_data_valid;
  logic             o_blob_seq;
  logic             o_blob_proc_ccd;
  logic             i_blob_valid = 1'b0;
  logic [CNT_W-1:0] i_blob_count = '0;
  logic             o_busy;
  logic             o_done;
  logic             o_timeout;
  logic [CNT_W-1:0] o_count;

  blob_frame_ctrl #(
    .IMG_COL (IMG_COL),
    .IMG_ROW (IMG_ROW),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_src_sdram       (i_src_sdram),
    .i_abort           (i_abort),
    .i_ccd_valid       (i_ccd_valid),
    .i_ccd_pix         (i_ccd_pix),
    .i_sdram_valid     (i_sdram_valid),
    .i_sdram_pix       (i_sdram_pix),
    .o_sdram_request   (o_sdram_request),
    .o_blob_valid      (o_blob_valid),
    .o_blob_data_valid (o_blob_data_valid),
    .o_blob_seq        (o_blob_seq),
    .o_blob_proc_ccd   (o_blob_proc_ccd),
    .i_blob_valid      (i_blob_valid),
    .i_blob_count      (i_blob_count),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_timeout         (o_timeout),
    .o_count           (o_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   pix_seen = 0;
  int   done_seen = 0;
  logic cur_src = 1'b0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every forwarded pixel must match the oldest pixel
  // driven on the selected source; request must only accompany an SDRAM frame.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_blob_data_valid) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          check("pix_extra", 32'(o_blob_data_valid), 0);
        end else begin
          check("pix_seq", 32'(o_blob_seq), 32'(exp_q.pop_front()));
        end
      end
      if (o_done) done_seen++;
      check("sdram_req", 32'(o_sdram_request), 32'(o_blob_valid & cur_src));
    end
  end

  task automatic drive_noise(input logic src, input logic noise);
    if (src) begin
      i_ccd_valid = noise ? 1'($urandom) : 1'b0;
      i_ccd_pix   = 1'($urandom);
    end else begin
      i_sdram_valid = noise ? 1'($urandom) : 1'b0;
      i_sdram_pix   = 1'($urandom);
    end
  endtask

  task automatic start_frame(input logic src);
    cur_src     = src;
    i_start     = 1'b1;
    i_src_sdram = src;
    tick();
    i_start = 1'b0;
    check("start_blob_valid", 32'(o_blob_valid), 1);
    check("start_busy", 32'(o_busy), 1);
    check("start_proc_ccd", 32'(o_blob_proc_ccd), 32'(!src));
  endtask

  task automatic stream(input logic src, input logic noise, input int gap, input int npix);
    for (int p = 0; p < npix; p++) begin
      logic pix;
      pix = 1'($urandom);
      if (src) begin
        i_sdram_valid = 1'b1;
        i_sdram_pix   = pix;
      end else begin
        i_ccd_valid = 1'b1;
        i_ccd_pix   = pix;
      end
      exp_q.push_back(pix);
      drive_noise(src, noise);
      tick();
      if (src) i_sdram_valid = 1'b0;
      else     i_ccd_valid   = 1'b0;
      if ((p % IMG_COL == IMG_COL - 1) && (p != npix - 1)) begin
        for (int g = 0; g < gap; g++) begin
          if (src) i_sdram_pix = 1'($urandom);
          else     i_ccd_pix   = 1'($urandom);
          drive_noise(src, noise);
          tick();
        end
      end
    end
    i_ccd_valid   = 1'b0;
    i_sdram_valid = 1'b0;
  endtask

  task automatic give_result(input logic [CNT_W-1:0] cnt);
    i_blob_valid = 1'b1;
    i_blob_count = cnt;
    tick();
    i_blob_valid = 1'b0;
  endtask

  typedef struct {
    logic       src;
    logic       noise;
    int         gap;
    int         abort_at;   // >0: abort after that many pixels, <0: abort in DRAIN
    int         res_delay;  // <0: never answer (timeout)
    logic [7:0] res_cnt;
    logic [7:0] exp_count;
    logic       exp_timeout;
    int         exp_done;
  } vec_t;

  vec_t vec[6];

  initial begin
    int d0;
    int p0;
    int npix;
    int k;

    vec[0] = '{1'b0, 1'b0, 20,  0, 50,  8'd37,  8'd37,  1'b0, 1};
    vec[1] = '{1'b0, 1'b1,  2, 24,  0,  8'd0,   8'd37,  1'b0, 0};
    vec[2] = '{1'b1, 1'b1,  3,  0,  0,  8'd200, 8'd200, 1'b0, 1};
    vec[3] = '{1'b0, 1'b1,  0,  0, -1,  8'd0,   8'd0,   1'b1, 1};
    vec[4] = '{1'b1, 1'b0,  1,  0,  7,  8'd9,   8'd9,   1'b0, 1};
    vec[5] = '{1'b0, 1'b0,  0, -1,  0,  8'd0,   8'd9,   1'b0, 0};

    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_proc_ccd", 32'(o_blob_proc_ccd), 1);
    check("rst_blob_valid", 32'(o_blob_valid), 0);
    check("rst_data_valid", 32'(o_blob_data_valid), 0);

    for (int i = 0; i < 6; i++) begin
      d0   = done_seen;
      p0   = pix_seen;
      npix = (vec[i].abort_at > 0) ? vec[i].abort_at : FRAME;
      start_frame(vec[i].src);
      stream(vec[i].src, vec[i].noise, vec[i].gap, npix);
      if (vec[i].abort_at != 0) begin
        if (vec[i].abort_at < 0) repeat (5) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_blob_valid", 32'(o_blob_valid), 0);
        check("abort_data_valid", 32'(o_blob_data_valid), 0);
        repeat (3) tick();
      end else begin
        check("drain_blob_valid", 32'(o_blob_valid), 0);
        check("drain_busy", 32'(o_busy), 1);
        if (vec[i].res_delay >= 0) begin
          repeat (vec[i].res_delay) tick();
          give_result(vec[i].res_cnt);
          check("done_pulse", 32'(o_done), 1);
        end else begin
          k = 0;
          while (!o_done && k < TIMEOUT + 20) begin
            tick();
            k++;
          end
          check("timeout_latency", 32'(k), TIMEOUT + 1);
        end
        tick();
        check("post_done_busy", 32'(o_busy), 0);
        check("post_done_done", 32'(o_done), 0);
      end
      check("vec_count", 32'(o_count), 32'(vec[i].exp_count));
      check("vec_timeout", 32'(o_timeout), 32'(vec[i].exp_timeout));
      check("vec_proc_ccd", 32'(o_blob_proc_ccd), 32'(!vec[i].src));
      check("vec_done_pulses", 32'(done_seen - d0), 32'(vec[i].exp_done));
      check("vec_pixels", 32'(pix_seen - p0), 32'(npix));
    end

    // i_start and i_blob_valid mid-stream are ignored: the frame continues
    // from where it was and the previous count survives.
    p0 = pix_seen;
    start_frame(1'b0);
    stream(1'b0, 1'b0, 0, 20);
    i_start      = 1'b1;
    i_src_sdram  = 1'b1;
    i_blob_valid = 1'b1;
    i_blob_count = 8'd99;
    tick();
    i_start      = 1'b0;
    i_blob_valid = 1'b0;
    check("ign_busy", 32'(o_busy), 1);
    check("ign_blob_valid", 32'(o_blob_valid), 1);
    check("ign_count", 32'(o_count), 9);
    check("ign_proc_ccd", 32'(o_blob_proc_ccd), 1);
    stream(1'b0, 1'b0, 0, FRAME - 20);
    check("ign_drain", 32'(o_blob_valid), 0);
    repeat (2) tick();
    give_result(8'd11);
    check("ign_done", 32'(o_done), 1);
    check("ign_final_count", 32'(o_count), 11);
    check("ign_pixels", 32'(pix_seen - p0), FRAME);
    tick();

    // Result on the last cycle before expiry beats the timeout.
    start_frame(1'b1);
    stream(1'b1, 1'b1, 0, FRAME);
    repeat (TIMEOUT) tick();
    check("sim_still_waiting", 32'(o_done), 0);
    give_result(8'd5);
    check("sim_done", 32'(o_done), 1);
    check("sim_count", 32'(o_count), 5);
    check("sim_timeout", 32'(o_timeout), 0);
    tick();

    // Reset mid-frame from an SDRAM frame, then a clean CCD frame.
    start_frame(1'b1);
    stream(1'b1, 1'b0, 2, 16);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    check("mrst_busy", 32'(o_busy), 0);
    check("mrst_blob_valid", 32'(o_blob_valid), 0);
    check("mrst_sdram_req", 32'(o_sdram_request), 0);
    check("mrst_count", 32'(o_count), 0);
    check("mrst_proc_ccd", 32'(o_blob_proc_ccd), 1);
    check("mrst_timeout", 32'(o_timeout), 0);
    tick();
    d0 = done_seen;
    p0 = pix_seen;
    start_frame(1'b0);
    stream(1'b0, 1'b1, 1, FRAME);
    give_result(8'd42);
    check("after_rst_done", 32'(o_done), 1);
    check("after_rst_count", 32'(o_count), 42);
    tick();
    check("after_rst_done_pulses", 32'(done_seen - d0), 1);
    check("after_rst_pixels", 32'(pix_seen - p0), FRAME);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
